in_port_burst_req: RTL and testbench

- Sits directly downstream of the native video input port.
- Consumes its frame/line/end alignment strobes and pixel-valid stream, one pixel = one write beat.
- Turns the beat stream into AXI-style write burst requests (start address + length) for the VDMA write address channel.
- Requests are buffered in a small request queue with a valid/ready handshake.

---
 rtl/in_port_burst_req.sv | 224 ++++++++++++++++++++++
 tb/tb_in_port_burst_req.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_port_burst_req.sv
// rtl/in_port_burst_req.sv - turns a video beat stream into VDMA write-burst requests
// A small show-ahead request queue sits between the burst builder and the address channel.

module in_port_burst_req_fifo #(
  parameter int DW    = 40,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          s_tvalid_i,
  input  logic [DW-1:0] s_tdata_i,
  output logic          s_drop_o,
  output logic          m_tvalid_o,
  input  logic          m_tready_i,
  output logic [DW-1:0] m_tdata_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign pop        = !empty && m_tready_i;
  // a pop in the same cycle frees the slot, so a full queue can still accept
  assign push       = s_tvalid_i && (!full || pop);
  assign s_drop_o   = s_tvalid_i && full && !pop;
  assign m_tvalid_o = !empty;
  assign m_tdata_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_tdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (!push && pop) count_q <= count_q - CNT_ONE;
    end
  end
endmodule

module in_port_burst_req #(
  parameter int    ASIZE      = 32,
  parameter int    BURST_LEN  = 16,
  parameter int    BEAT_BYTES = 4,
  parameter int    QDEPTH     = 4,
  parameter string MODE       = "ONCE"
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ASIZE-1:0] baseaddr,
  input  logic [ASIZE-1:0] line_stride,
  input  logic             falign,
  input  logic             lalign,
  input  logic             ealign,
  input  logic             idata_vld,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ASIZE-1:0] req_addr,
  output logic [7:0]       req_len,
  output logic             frame_done,
  output logic             overflow
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]    LAST_BEAT   = CW'(BURST_LEN - 1);
  localparam logic [7:0]       FULL_LEN    = 8'(BURST_LEN - 1);
  localparam logic [ASIZE-1:0] BURST_BYTES = ASIZE'(BURST_LEN * BEAT_BYTES);
  localparam bit               LINE_MODE   = (MODE == "LINE");

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] burst_addr_q, burst_addr_d;
  logic [ASIZE-1:0] line_base_q, line_base_d;
  logic [ASIZE-1:0] stride_q, stride_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovf_clr;
  logic             full_hit;
  logic             push_vld;
  logic [ASIZE-1:0] push_addr;
  logic [7:0]       push_len;
  logic             q_drop, q_valid;
  logic [ASIZE+7:0] q_data;

  assign full_hit = idata_vld && (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    line_base_d  = line_base_q;
    stride_d     = stride_q;
    beat_cnt_d   = beat_cnt_q;
    push_vld     = 1'b0;
    push_addr    = burst_addr_q;
    push_len     = FULL_LEN;
    frame_done   = 1'b0;
    ovf_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (falign && enable) begin
          state_d      = ACTIVE;
          stride_d     = line_stride;
          line_base_d  = baseaddr;
          burst_addr_d = baseaddr;
          beat_cnt_d   = '0;
          ovf_clr      = 1'b1;
        end
      end
      ACTIVE: begin
        if (falign) begin
          // unterminated frame: close the old partial, then restart or stop
          if (full_hit) begin
            push_vld = 1'b1;
          end else if (beat_cnt_q != '0) begin
            push_vld = 1'b1;
            push_len = 8'(beat_cnt_q - CNT_ONE);
          end
          beat_cnt_d = '0;
          if (enable) begin
            stride_d     = line_stride;
            line_base_d  = baseaddr;
            burst_addr_d = baseaddr;
            ovf_clr      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (ealign) begin
          // a coincident beat belongs to the burst being closed
          if (full_hit) begin
            push_vld = 1'b1;
          end else if (idata_vld) begin
            push_vld = 1'b1;
            push_len = 8'(beat_cnt_q);
          end else if (beat_cnt_q != '0) begin
            push_vld = 1'b1;
            push_len = 8'(beat_cnt_q - CNT_ONE);
          end
          beat_cnt_d = '0;
          state_d    = FLUSH;
        end else if (LINE_MODE && lalign) begin
          // a non-completing coincident beat opens the next line
          if (full_hit) begin
            push_vld   = 1'b1;
            beat_cnt_d = '0;
          end else begin
            if (beat_cnt_q != '0) begin
              push_vld = 1'b1;
              push_len = 8'(beat_cnt_q - CNT_ONE);
            end
            beat_cnt_d = idata_vld ? CNT_ONE : '0;
          end
          line_base_d  = line_base_q + stride_q;
          burst_addr_d = line_base_q + stride_q;
        end else if (full_hit) begin
          push_vld     = 1'b1;
          burst_addr_d = burst_addr_q + BURST_BYTES;
          beat_cnt_d   = '0;
        end else if (idata_vld) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
      end
      FLUSH: begin
        if (!q_valid) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_clr ? 1'b0 : (ovf_q | q_drop);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      burst_addr_q <= '0;
      line_base_q  <= '0;
      stride_q     <= '0;
      beat_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      line_base_q  <= line_base_d;
      stride_q     <= stride_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  in_port_burst_req_fifo #(
    .DW    (ASIZE + 8),
    .DEPTH (QDEPTH)
  ) u_req_q (
    .clock      (clock),
    .rst_n      (rst_n),
    .s_tvalid_i (push_vld),
    .s_tdata_i  ({push_addr, push_len}),
    .s_drop_o   (q_drop),
    .m_tvalid_o (q_valid),
    .m_tready_i (req_ready),
    .m_tdata_o  (q_data)
  );

  assign req_valid = q_valid;
  assign req_addr  = q_data[ASIZE+7:8];
  assign req_len   = q_data[7:0];
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_in_port_burst_req.sv
// tb/tb_in_port_burst_req.sv - directed bench for in_port_burst_req in ONCE and LINE modes
module tb_in_port_burst_req;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, falign = 1'b0, lalign = 1'b0, ealign = 1'b0;
  logic        idata_vld = 1'b0, req_ready = 1'b0;
  logic [31:0] baseaddr = 32'h0, line_stride = 32'h800;
  logic        o_valid, l_valid, o_fd, l_fd, o_ovf, l_ovf;
  logic [31:0] o_addr, l_addr;
  logic [7:0]  o_len, l_len;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  in_port_burst_req #(.MODE("ONCE")) dut_once (
    .clock(clock), .rst_n(rst_n), .enable(enable), .baseaddr(baseaddr),
    .line_stride(line_stride), .falign(falign), .lalign(lalign), .ealign(ealign),
    .idata_vld(idata_vld), .req_valid(o_valid), .req_ready(req_ready),
    .req_addr(o_addr), .req_len(o_len), .frame_done(o_fd), .overflow(o_ovf));

  in_port_burst_req #(.MODE("LINE")) dut_line (
    .clock(clock), .rst_n(rst_n), .enable(enable), .baseaddr(baseaddr),
    .line_stride(line_stride), .falign(falign), .lalign(lalign), .ealign(ealign),
    .idata_vld(idata_vld), .req_valid(l_valid), .req_ready(req_ready),
    .req_addr(l_addr), .req_len(l_len), .frame_done(l_fd), .overflow(l_ovf));

  typedef struct {
    bit          line;
    logic [31:0] base;
    int          nl;
    int          bl [2];
    int          lmode;   // 0 none, 1 own cycle after line, 2 on first beat of next line, 3 on last beat
    int          emode;   // 0 own cycle after frame, 1 on last beat
    int          nexp;
    logic [31:0] ea [4];
    logic [7:0]  el [4];
  } vec_t;

  vec_t        tbl [7];
  logic [39:0] qo[$];
  logic [39:0] ql[$];
  int          fd_o = 0, fd_l = 0, pops_at_fd = 0;

  always @(negedge clock) begin
    if (rst_n) begin
      if (o_valid && req_ready) qo.push_back({o_addr, o_len});
      if (l_valid && req_ready) ql.push_back({l_addr, l_len});
      if (o_fd) begin
        fd_o++;
        pops_at_fd = qo.size();
      end
      if (l_fd) fd_l++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_falign();
    falign = 1'b1;
    cycle();
    falign = 1'b0;
  endtask

  task automatic pulse_ealign();
    ealign = 1'b1;
    cycle();
    ealign = 1'b0;
  endtask

  task automatic beats(input int n);
    idata_vld = 1'b1;
    repeat (n) cycle();
    idata_vld = 1'b0;
  endtask

  task automatic wait_fd(input bit line, input int fd0, input int budget);
    int cyc;
    cyc = 0;
    while (((line ? fd_l : fd_o) == fd0) && cyc < budget) begin
      cycle();
      cyc++;
    end
    if ((line ? fd_l : fd_o) == fd0) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_done_timeout: got none within %0d cycles, required a pulse", budget);
    end
  endtask

  task automatic set_vec(input int i, input bit line, input logic [31:0] base, input int nl,
                         input int b0, input int b1, input int lmode, input int emode, input int nexp,
                         input logic [31:0] a0, input logic [7:0] l0, input logic [31:0] a1, input logic [7:0] l1,
                         input logic [31:0] a2, input logic [7:0] l2, input logic [31:0] a3, input logic [7:0] l3);
    tbl[i].line  = line;  tbl[i].base  = base;  tbl[i].nl = nl;
    tbl[i].bl[0] = b0;    tbl[i].bl[1] = b1;
    tbl[i].lmode = lmode; tbl[i].emode = emode; tbl[i].nexp = nexp;
    tbl[i].ea[0] = a0; tbl[i].el[0] = l0; tbl[i].ea[1] = a1; tbl[i].el[1] = l1;
    tbl[i].ea[2] = a2; tbl[i].el[2] = l2; tbl[i].ea[3] = a3; tbl[i].el[3] = l3;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   i0, fd0, got, last;
    logic [39:0] r;
    v   = tbl[idx];
    i0  = v.line ? ql.size() : qo.size();
    fd0 = v.line ? fd_l : fd_o;
    req_ready = 1'b1;
    enable    = 1'b1;
    baseaddr  = v.base;
    pulse_falign();
    for (int l = 0; l < v.nl; l++) begin
      for (int b = 0; b < v.bl[l]; b++) begin
        last      = v.bl[l] - 1;
        idata_vld = 1'b1;
        lalign    = (v.lmode == 2 && l > 0 && b == 0) || (v.lmode == 3 && b == last);
        ealign    = (v.emode == 1 && l == v.nl - 1 && b == last);
        cycle();
      end
      idata_vld = 1'b0;
      lalign    = 1'b0;
      ealign    = 1'b0;
      if (v.lmode == 1) begin
        lalign = 1'b1;
        cycle();
        lalign = 1'b0;
      end
    end
    if (v.emode == 0) pulse_ealign();
    wait_fd(v.line, fd0, 200);
    repeat (4) cycle();
    got = (v.line ? ql.size() : qo.size()) - i0;
    check($sformatf("v%0d_req_count", idx), got, v.nexp);
    for (int i = 0; i < v.nexp; i++) begin
      if (i < got) begin
        r = v.line ? ql[i0 + i] : qo[i0 + i];
        check($sformatf("v%0d_req%0d_addr", idx, i), r[39:8], v.ea[i]);
        check($sformatf("v%0d_req%0d_len", idx, i), r[7:0], v.el[i]);
      end
    end
    check($sformatf("v%0d_frame_done_pulses", idx), (v.line ? fd_l : fd_o) - fd0, 1);
  endtask

  initial begin
    int ob, lb, fb, flb;
    logic [39:0] r;

    rst_n = 1'b0;
    repeat (3) cycle();
    check("rst_req_valid", o_valid, 0);
    check("rst_overflow", o_ovf, 0);
    check("rst_frame_done", o_fd, 0);
    check("rst_req_addr", o_addr, 0);
    check("rst_req_len", o_len, 0);
    check("rst_line_req_valid", l_valid, 0);
    rst_n = 1'b1;
    cycle();

    set_vec(0, 0, 32'h1000, 1, 40, 0, 0, 0, 3,
            32'h1000, 8'd15, 32'h1040, 8'd15, 32'h1080, 8'd7, 32'h0, 8'd0);
    set_vec(1, 1, 32'h1000, 2, 20, 20, 1, 0, 4,
            32'h1000, 8'd15, 32'h1040, 8'd3, 32'h1800, 8'd15, 32'h1840, 8'd3);
    set_vec(2, 1, 32'h1000, 2, 16, 16, 2, 0, 2,
            32'h1000, 8'd15, 32'h1800, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);
    set_vec(3, 0, 32'h1000, 1, 6, 0, 0, 1, 1,
            32'h1000, 8'd5, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);
    set_vec(4, 0, 32'h1000, 1, 16, 0, 0, 1, 1,
            32'h1000, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);
    set_vec(5, 1, 32'h1000, 2, 16, 4, 3, 0, 3,
            32'h1000, 8'd15, 32'h1800, 8'd2, 32'h2000, 8'd0, 32'h0, 8'd0);
    set_vec(6, 0, 32'hFFFF_FFF0, 1, 20, 0, 0, 0, 2,
            32'hFFFF_FFF0, 8'd15, 32'h0000_0030, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0);

    for (int k = 0; k < 7; k++) run_vec(k);

    // back-pressure: six bursts into a four-deep queue
    ob = qo.size();
    fb = fd_o;
    req_ready = 1'b0;
    enable    = 1'b1;
    baseaddr  = 32'h1000;
    pulse_falign();
    beats(96);
    pulse_ealign();
    repeat (10) cycle();
    check("bp_overflow_set", o_ovf, 1);
    check("bp_req_valid", o_valid, 1);
    check("bp_no_early_frame_done", fd_o - fb, 0);
    req_ready = 1'b1;
    wait_fd(1'b0, fb, 50);
    check("bp_pops_before_done", pops_at_fd - ob, 4);
    repeat (4) cycle();
    check("bp_pop_count", qo.size() - ob, 4);
    for (int i = 0; i < 4; i++) begin
      if (ob + i < qo.size()) begin
        r = qo[ob + i];
        check($sformatf("bp_req%0d_addr", i), r[39:8], 32'h1000 + 32'h40 * i);
        check($sformatf("bp_req%0d_len", i), r[7:0], 15);
      end
    end
    check("bp_overflow_sticky", o_ovf, 1);
    pulse_falign();
    check("bp_overflow_cleared", o_ovf, 0);
    fb = fd_o;
    pulse_ealign();
    wait_fd(1'b0, fb, 50);
    repeat (4) cycle();

    // disarmed: falign with enable low starts nothing
    ob  = qo.size();
    lb  = ql.size();
    fb  = fd_o;
    flb = fd_l;
    enable = 1'b0;
    pulse_falign();
    beats(20);
    pulse_ealign();
    repeat (10) cycle();
    check("dis_once_reqs", qo.size() - ob, 0);
    check("dis_line_reqs", ql.size() - lb, 0);
    check("dis_frame_done", (fd_o - fb) + (fd_l - flb), 0);
    check("dis_req_valid", o_valid, 0);
    enable = 1'b1;

    // asynchronous reset in the middle of a burst with a full queue
    req_ready = 1'b0;
    pulse_falign();
    beats(85);
    check("mid_pre_overflow", o_ovf, 1);
    idata_vld = 1'b1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_req_valid", o_valid, 0);
    check("mid_rst_overflow", o_ovf, 0);
    check("mid_rst_frame_done", o_fd, 0);
    check("mid_rst_req_addr", o_addr, 0);
    check("mid_rst_line_valid", l_valid, 0);
    idata_vld = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("post_rst_queue_empty", o_valid, 0);
    check("post_rst_line_empty", l_valid, 0);
    check("post_rst_frame_done", o_fd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
